// File: rtl/simon_sequence_store.sv
// Colour-sequence memory for a Simon-style game: appends colours, plays them back
// over a valid/ready handshake, then checks the player's entries against the stored order.
module simon_sequence_store #(
    parameter int DEPTH    = 32,
    parameter int COLOUR_W = 3,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [COLOUR_W-1:0] new_colour,
    input  logic                play_start,
    output logic [COLOUR_W-1:0] play_colour,
    output logic                play_valid,
    input  logic                play_ready,
    input  logic                check_valid,
    input  logic [COLOUR_W-1:0] check_colour,
    output logic                play_done,
    output logic                check_match,
    output logic                check_mismatch,
    output logic                round_complete,
    output logic                overflow,
    output logic [CNT_W-1:0]    length,
    output logic                full,
    output logic                busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     length_reg;
    logic [CNT_W-1:0]     rd_ptr_reg;
    logic [COLOUR_W-1:0]  mem [DEPTH];

    logic play_done_reg;
    logic check_match_reg;
    logic check_mismatch_reg;
    logic round_complete_reg;
    logic overflow_reg;

    logic                full_int;
    logic                at_last;
    logic [COLOUR_W-1:0] rd_colour;
    logic                colour_hit;

    assign full_int   = (length_reg == CNT_W'(DEPTH));
    // Only meaningful in PLAY/CHECK, where length_reg is at least 1.
    assign at_last    = (rd_ptr_reg == length_reg - CNT_W'(1));
    assign rd_colour  = mem[rd_ptr_reg[AW-1:0]];
    assign colour_hit = (check_colour == rd_colour);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            length_reg         <= '0;
            rd_ptr_reg         <= '0;
            play_done_reg      <= 1'b0;
            check_match_reg    <= 1'b0;
            check_mismatch_reg <= 1'b0;
            round_complete_reg <= 1'b0;
            overflow_reg       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            play_done_reg      <= 1'b0;
            check_match_reg    <= 1'b0;
            check_mismatch_reg <= 1'b0;
            round_complete_reg <= 1'b0;
            overflow_reg       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A load always wins over a simultaneous play_start.
                    if (load) begin
                        if (full_int) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            mem[length_reg[AW-1:0]] <= new_colour;
                            length_reg              <= length_reg + CNT_W'(1);
                        end
                    end else if (play_start && (length_reg != '0)) begin
                        rd_ptr_reg <= '0;
                        state_reg  <= PLAY;
                    end
                end

                PLAY: begin
                    if (play_ready) begin
                        if (at_last) begin
                            rd_ptr_reg    <= '0;
                            state_reg     <= CHECK;
                            play_done_reg <= 1'b1;
                        end else begin
                            rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
                        end
                    end
                end

                CHECK: begin
                    if (check_valid) begin
                        if (colour_hit) begin
                            check_match_reg <= 1'b1;
                            if (at_last) begin
                                round_complete_reg <= 1'b1;
                                rd_ptr_reg         <= '0;
                                state_reg          <= IDLE;
                            end else begin
                                rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
                            end
                        end else begin
                            check_mismatch_reg <= 1'b1;
                            rd_ptr_reg         <= '0;
                            state_reg          <= IDLE;
                        end
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    rd_ptr_reg <= '0;
                end
            endcase
        end
    end

    assign play_valid     = (state_reg == PLAY);
    assign play_colour    = (state_reg == PLAY) ? rd_colour : '0;
    assign play_done      = play_done_reg;
    assign check_match    = check_match_reg;
    assign check_mismatch = check_mismatch_reg;
    assign round_complete = round_complete_reg;
    assign overflow       = overflow_reg;
    assign length         = length_reg;
    assign full           = full_int;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_simon_sequence_store.sv
// Randomized scoreboard bench for simon_sequence_store: a queue-based game model predicts
// every handshake and pulse; a negedge monitor pops and compares what the DUT presents.
module tb_simon_sequence_store;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [CW-1:0]    new_colour = '0;
    logic             play_start = 1'b0;
    logic [CW-1:0]    play_colour;
    logic             play_valid;
    logic             play_ready = 1'b0;
    logic             check_valid = 1'b0;
    logic [CW-1:0]    check_colour = '0;
    logic             play_done, check_match, check_mismatch, round_complete, overflow;
    logic [CNT_W-1:0] length;
    logic             full, busy;

    simon_sequence_store #(.DEPTH(DEPTH), .COLOUR_W(CW)) dut (
        .clk(clk), .reset(reset), .load(load), .new_colour(new_colour),
        .play_start(play_start), .play_colour(play_colour), .play_valid(play_valid),
        .play_ready(play_ready), .check_valid(check_valid), .check_colour(check_colour),
        .play_done(play_done), .check_match(check_match), .check_mismatch(check_mismatch),
        .round_complete(round_complete), .overflow(overflow), .length(length),
        .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hs;
        logic [CW-1:0] col;
        logic          done;
        logic          match;
        logic          mism;
        logic          rc;
        logic          ovf;
    } ev_t;

    ev_t exp_q[$];
    int  seq[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic ev_t mk(input bit hs, input int col, input bit done, input bit match,
                               input bit mism, input bit rc, input bit ovf);
        ev_t e;
        e.hs = hs; e.col = CW'(col); e.done = done; e.match = match;
        e.mism = mism; e.rc = rc; e.ovf = ovf;
        return e;
    endfunction

    // Monitor: one observation per cycle in which the DUT shows a handshake or any pulse.
    always @(negedge clk) begin
        ev_t obs;
        ev_t e;
        obs = '0;
        if (!reset) begin
            obs.hs    = play_valid && play_ready;
            obs.col   = obs.hs ? play_colour : '0;
            obs.done  = play_done;
            obs.match = check_match;
            obs.mism  = check_mismatch;
            obs.rc    = round_complete;
            obs.ovf   = overflow;
            if (obs != '0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_event", int'(obs), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_event", int'(obs), int'(e));
                    $display("event hs=%0b col=%0d done=%0b match=%0b mism=%0b rc=%0b ovf=%0b",
                             obs.hs, obs.col, obs.done, obs.match, obs.mism, obs.rc, obs.ovf);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step();
        reset = 1'b1; load = 1'b0; play_start = 1'b0; play_ready = 1'b0; check_valid = 1'b0;
        step();
        reset = 1'b0;
        seq.delete();
    endtask

    task automatic load_c(input int c, input bit with_play);
        load = 1'b1; new_colour = CW'(c); play_start = with_play;
        if (seq.size() == DEPTH) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        else seq.push_back(c);
        step();
        load = 1'b0; play_start = 1'b0;
        @(negedge clk);
        step();
    endtask

    task automatic play(input int stall_at, input int stop_after, input bit rnd);
        int n, lim, cnt, cycles, stalls;
        bit stalling;
        n = seq.size();
        lim = (stop_after >= 0) ? stop_after : n;
        cnt = 0; cycles = 0; stalls = 0;
        for (int i = 0; i < lim; i++) exp_q.push_back(mk(1, seq[i], 0, 0, 0, 0, 0));
        if (stop_after < 0) exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        while (cnt < lim && cycles < 200) begin
            stalling   = (cnt == stall_at) && (stalls < 3);
            play_ready = stalling ? 1'b0 : (rnd ? ($urandom % 3 != 0) : 1'b1);
            load       = rnd ? ($urandom % 4 == 0) : 1'b0;
            new_colour = CW'($urandom);
            @(negedge clk);
            if (stalling) begin
                chk("stall_valid", int'(play_valid), 1);
                chk("stall_colour", int'(play_colour), seq[stall_at]);
                stalls++;
            end
            if (play_valid && play_ready) cnt++;
            cycles++;
            step();
        end
        play_ready = 1'b0; load = 1'b0;
        if (cnt < lim) chk("play_timeout", cnt, lim);
        if (!rnd && stall_at < 0) chk("play_cycles", cycles, lim);
        if (stop_after < 0) begin
            @(negedge clk);
            chk("play_done_timing", int'(play_done), 1);
            step();
        end
    endtask

    task automatic check(input int mistake_at, input int wrong, input bit rnd);
        int n, j, cycles;
        bit done;
        n = seq.size(); j = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 200) begin
            play_ready = rnd ? 1'($urandom) : 1'b0;
            load       = rnd ? ($urandom % 4 == 0) : 1'b0;
            new_colour = CW'($urandom);
            if (rnd && ($urandom % 4 == 0)) begin
                check_valid = 1'b0;
            end else begin
                check_valid = 1'b1;
                if (j == mistake_at) begin
                    check_colour = (wrong >= 0) ? CW'(wrong) : CW'(seq[j] + 1 + int'($urandom % 7));
                    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
                    done = 1'b1;
                end else begin
                    check_colour = CW'(seq[j]);
                    exp_q.push_back(mk(0, 0, 0, 1, 0, j == n - 1, 0));
                    if (j == n - 1) done = 1'b1;
                end
                j++;
            end
            cycles++;
            step();
        end
        check_valid = 1'b0; play_ready = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("busy_after_check", int'(busy), 0);
        step();
    endtask

    initial begin
        int act, nl;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_length", int'(length), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_play_valid", int'(play_valid), 0);
        chk("reset_play_colour", int'(play_colour), 0);
        chk("reset_pulses", int'({play_done, check_match, check_mismatch, round_complete, overflow}), 0);
        step();

        // Load 1,2,3, play back, check all correct.
        load_c(1, 0); load_c(2, 0); load_c(3, 0);
        chk("length_3", int'(length), 3);
        play(-1, -1, 0);
        check(-1, -1, 0);

        // Stall during playback, then a wrong second entry.
        play(1, -1, 0);
        check(1, 4, 0);
        chk("length_after_mismatch", int'(length), 3);

        // Reset mid-playback at rd_ptr=2.
        play(-1, 2, 0);
        reset_dut();
        chk("midplay_reset_length", int'(length), 0);
        chk("midplay_reset_valid", int'(play_valid), 0);
        chk("midplay_reset_busy", int'(busy), 0);
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        chk("empty_play_start_busy", int'(busy), 0);

        // Overflow with DEPTH=4, then prove stored colours survived.
        load_c(5, 0); load_c(6, 0); load_c(7, 0); load_c(1, 0); load_c(2, 0);
        chk("overflow_length", int'(length), 4);
        chk("overflow_full", int'(full), 1);
        play(-1, -1, 0);
        check(-1, -1, 0);

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            act = int'($urandom % 6);
            if (act == 0) begin
                reset_dut();
            end else if (act <= 2) begin
                nl = 1 + int'($urandom % 2);
                for (int k = 0; k < nl; k++) load_c(int'($urandom % 8), 1'($urandom));
            end else if (seq.size() == 0) begin
                play_start = 1'b1;
                step();
                play_start = 1'b0;
                chk("empty_play_busy", int'(busy), 0);
            end else begin
                play(-1, -1, 1);
                check(($urandom % 2 == 0) ? -1 : int'($urandom % seq.size()), -1, 1);
            end
            chk("round_length", int'(length), seq.size());
            chk("round_full", int'(full), int'(seq.size() == DEPTH));
        end

        repeat (3) step();
        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
